// File: rtl/chan_rotator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : chan_rotator                                                  |
// | Brief    : Steps a channel index up/down and registers the selected      |
// |            channel word. Macro CHAN_ROTATOR_EDGE_EN: advance on d edge.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module chan_rotator #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     d,
  input  logic                     dir,
  input  logic                     hold,
  input  logic                     clr,
  input  logic [NCH*WIDTH-1:0]     data_in,
  output logic [WIDTH-1:0]         x_var,
  output logic [$clog2(NCH)-1:0]   sel,
  output logic                     wrap,
  output logic                     active
);

  localparam int                 c_sel_w = $clog2(NCH);
  localparam logic [c_sel_w-1:0] c_last  = c_sel_w'(NCH - 1);
  localparam logic [c_sel_w-1:0] c_one   = c_sel_w'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FROZEN = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_sel_w-1:0]   r_sel;
  logic [WIDTH-1:0]     r_x;
  logic                 r_wrap;
  logic                 r_active;

  logic                 w_adv;
  logic [WIDTH-1:0]     w_sel_data;
  logic [c_sel_w-1:0]   w_sel_step;
  logic                 w_step_wraps;

`ifdef CHAN_ROTATOR_EDGE_EN
  // d history runs in every state so an edge seen while frozen is spent there
  logic r_d_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_d_prev <= 1'b0;
    end else begin
      r_d_prev <= d;
    end
  end

  assign w_adv = d & ~r_d_prev;
`else
  assign w_adv = d;
`endif

  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (r_sel == c_sel_w'(k)) begin
        w_sel_data = data_in[k*WIDTH +: WIDTH];
      end
    end
  end

  // Modular step; >= guards keep the index inside 0..NCH-1 for any NCH
  always_comb begin
    w_sel_step   = r_sel;
    w_step_wraps = 1'b0;
    if (dir) begin
      if (r_sel == '0) begin
        w_sel_step   = c_last;
        w_step_wraps = 1'b1;
      end else begin
        w_sel_step   = r_sel - c_one;
      end
    end else begin
      if (r_sel >= c_last) begin
        w_sel_step   = '0;
        w_step_wraps = 1'b1;
      end else begin
        w_sel_step   = r_sel + c_one;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_sel    <= '0;
      r_x      <= '0;
      r_wrap   <= 1'b0;
      r_active <= 1'b0;
    end else if (clr) begin
      r_state  <= ST_IDLE;
      r_sel    <= '0;
      r_x      <= '0;
      r_wrap   <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_sel <= '0;
          r_x   <= '0;
          if (w_adv) begin
            r_state  <= ST_ACTIVE;
            r_active <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (hold) begin
            r_state  <= ST_FROZEN;
            r_active <= 1'b0;
          end else begin
            // x_var follows the index as it stood before this edge
            r_x <= w_sel_data;
            if (w_adv) begin
              r_sel  <= w_sel_step;
              r_wrap <= w_step_wraps;
            end
          end
        end
        ST_FROZEN: begin
          if (!hold) begin
            r_state  <= ST_ACTIVE;
            r_active <= 1'b1;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_sel    <= '0;
          r_x      <= '0;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign x_var  = r_x;
  assign sel    = r_sel;
  assign wrap   = r_wrap;
  assign active = r_active;

endmodule
`default_nettype wire

// File: tb/tb_chan_rotator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_chan_rotator                                               |
// | Brief    : Randomised bench for chan_rotator (NCH=4 and NCH=3 copies)    |
// |            against a behavioural model of the rotation rules.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_chan_rotator;

  logic        clk;
  logic        reset;
  logic        d, dir, hold, clr;
  logic [31:0] data_in4;
  logic [23:0] data_in3;

  logic [7:0]  x4, x3;
  logic [1:0]  sel4, sel3;
  logic        wrap4, wrap3, active4, active3;

  int n_checks;
  int n_fail;

  // Model: state 0=idle 1=active 2=frozen; index 0 -> NCH=4, 1 -> NCH=3
  int m_nch   [2] = '{4, 3};
  int m_state [2];
  int m_sel   [2];
  int m_x     [2];
  int m_wrap  [2];
  bit m_dprev [2];

  assign data_in3 = data_in4[23:0];

  chan_rotator #(.WIDTH(8), .NCH(4)) u_dut4 (
    .clk(clk), .reset(reset), .d(d), .dir(dir), .hold(hold), .clr(clr),
    .data_in(data_in4), .x_var(x4), .sel(sel4), .wrap(wrap4), .active(active4)
  );

  chan_rotator #(.WIDTH(8), .NCH(3)) u_dut3 (
    .clk(clk), .reset(reset), .d(d), .dir(dir), .hold(hold), .clr(clr),
    .data_in(data_in3), .x_var(x3), .sel(sel3), .wrap(wrap3), .active(active3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int chan_word(int k);
    return int'((data_in4 >> (8 * k)) & 32'hFF);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = 0; m_sel[i] = 0; m_x[i] = 0; m_wrap[i] = 0; m_dprev[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit adv;
    for (int i = 0; i < 2; i++) begin
`ifdef CHAN_ROTATOR_EDGE_EN
      adv = d && !m_dprev[i];
`else
      adv = d;
`endif
      m_wrap[i] = 0;
      if (clr) begin
        m_state[i] = 0; m_sel[i] = 0; m_x[i] = 0;
      end else if (m_state[i] == 0) begin
        m_sel[i] = 0; m_x[i] = 0;
        if (adv) m_state[i] = 1;
      end else if (m_state[i] == 1) begin
        if (hold) begin
          m_state[i] = 2;
        end else begin
          m_x[i] = chan_word(m_sel[i]);
          if (adv) begin
            m_sel[i] = dir ? (m_sel[i] + m_nch[i] - 1) % m_nch[i] : (m_sel[i] + 1) % m_nch[i];
            m_wrap[i] = dir ? int'(m_sel[i] == m_nch[i] - 1) : int'(m_sel[i] == 0);
          end
        end
      end else begin
        if (!hold) m_state[i] = 1;
      end
      m_dprev[i] = d;
    end
  endtask

  task automatic compare_all();
    check("sel4",    sel4,    m_sel[0]);
    check("x4",      x4,      m_x[0]);
    check("wrap4",   wrap4,   m_wrap[0]);
    check("active4", active4, int'(m_state[0] == 1));
    check("sel3",    sel3,    m_sel[1]);
    check("x3",      x3,      m_x[1]);
    check("wrap3",   wrap3,   m_wrap[1]);
    check("active3", active3, int'(m_state[1] == 1));
  endtask

  // Inputs are stable across the edge; outputs compared 1 ns after it
  task automatic tick();
    @(posedge clk);
    if (!reset) model_reset();
    else model_edge();
    #1;
    compare_all();
  endtask

  // Pulse reset between edges and check outputs clear without a clock
  task automatic async_reset();
    #3 reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    #2 reset = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b0; d = 1'b0; dir = 1'b0; hold = 1'b0; clr = 1'b0;
    data_in4 = 32'h44332211;
    model_reset();
    tick(); tick();
    reset = 1'b1;
    tick();

    // Single d pulse: enter ACTIVE at sel 0, data follows a cycle later
    d = 1'b1; tick();
    check("enter_active", active4, 1);
    d = 1'b0; tick();
    check("first_x", x4, 8'h11);
    check("first_sel", sel4, 0);

    // d held high for several cycles, stepping up
    d = 1'b1; dir = 1'b0;
    repeat (5) tick();
    d = 1'b0; tick(); tick();

    // Return to sel 0, then one downward step wraps to NCH-1
    clr = 1'b1; tick(); clr = 1'b0;
    d = 1'b1; tick(); d = 1'b0; tick();
    dir = 1'b1; d = 1'b1; tick();
    check("down_sel", sel4, 3);
    check("down_wrap", wrap4, 1);
    check("down_sel3", sel3, 2);
    d = 1'b0; dir = 1'b0; tick();
    check("down_wrap_off", wrap4, 0);
    check("down_x", x4, 8'h44);

    // Up to sel 1, then hold with adv freezes; d edge while frozen
    d = 1'b1; tick(); d = 1'b0; tick();
    d = 1'b1; tick(); d = 1'b0; tick();
    check("pre_hold_sel", sel4, 1);
    check("pre_hold_x", x4, 8'h22);
    hold = 1'b1; d = 1'b1; tick();
    check("frozen_sel", sel4, 1);
    check("frozen_x", x4, 8'h22);
    check("frozen_active", active4, 0);
    d = 1'b0; tick();
    d = 1'b1; tick();
    hold = 1'b0; tick();
    tick(); tick();
    d = 1'b0; tick();

    // Clear mid-run
    d = 1'b1; tick(); tick();
    clr = 1'b1; tick(); clr = 1'b0; d = 1'b0;
    check("clr_sel3", sel3, 0);
    check("clr_x3", x3, 0);
    check("clr_active3", active3, 0);

    // Asynchronous reset during ACTIVE; d low afterwards keeps IDLE
    d = 1'b1; tick(); tick(); d = 1'b0; tick();
    async_reset();
    repeat (3) tick();
    check("post_reset_idle", active4, 0);

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      d    = 1'($urandom_range(0, 1));
      dir  = 1'($urandom_range(0, 1));
      hold = ($urandom_range(0, 5) == 0);
      clr  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 7) == 0) data_in4 = $urandom;
      if ($urandom_range(0, 149) == 0) async_reset();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
